// File: rtl/alu_flag_unit_pkg.sv
// rtl/alu_flag_unit_pkg.sv - shared PSR layout and branch condition codes
package alu_flag_unit_pkg;

    typedef logic [3:0] psr_t;

    localparam int PSR_N = 3;
    localparam int PSR_Z = 2;
    localparam int PSR_C = 1;
    localparam int PSR_V = 0;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/alu_flag_unit_stack.sv
// rtl/alu_flag_unit_stack.sv - DEPTH x 4 LIFO shadow stack for PSR save/restore
module flag_stack
    import alu_flag_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic err_clr,
    input  psr_t wdata,
    output psr_t rdata,
    output logic pop_ok,
    output logic full,
    output logic empty,
    output logic err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;
    psr_t          mem_q [DEPTH];
    logic          push_only, pop_only, push_ok, err_set;
    logic [AW-1:0] wr_idx, rd_idx;

    assign full   = (ptr_q == PW'(DEPTH));
    assign empty  = (ptr_q == '0);
    assign err    = err_q;
    assign wr_idx = ptr_q[AW-1:0];
    assign rd_idx = AW'(ptr_q - PW'(1));
    assign rdata  = mem_q[rd_idx];

    // Simultaneous push and pop cancel each other and are not an error.
    assign push_only = push & ~pop;
    assign pop_only  = pop & ~push;
    assign push_ok   = push_only & ~full;
    assign pop_ok    = pop_only & ~empty;
    assign err_set   = (push_only & full) | (pop_only & empty);

    always_comb begin
        ptr_d = ptr_q;
        if (push_ok) begin
            ptr_d = ptr_q + PW'(1);
        end else if (pop_ok) begin
            ptr_d = ptr_q - PW'(1);
        end
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/alu_flag_unit.sv
// rtl/alu_flag_unit.sv - PSR latch, branch condition evaluator and shadow stack top
module alu_flag_unit
    import alu_flag_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flag_we,
    input  logic       c_in,
    input  logic       v_in,
    input  logic       n_in,
    input  logic       z_in,
    input  logic [3:0] flag_mask,
    input  logic [3:0] cond,
    input  logic       cond_valid,
    output logic       taken,
    output logic       taken_valid,
    input  logic       push,
    input  logic       pop,
    output logic [3:0] psr,
    output logic       carry_out,
    output logic       full,
    output logic       empty,
    output logic       stack_err,
    input  logic       err_clr
);

    psr_t psr_q, psr_d;
    logic taken_q, taken_d;
    logic taken_valid_q, taken_valid_d;
    logic cond_true;
    logic f_n, f_z, f_c, f_v;
    psr_t flag_new, stack_rdata;
    logic pop_ok;

    flag_stack #(.DEPTH(DEPTH)) u_stack (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .err_clr(err_clr),
        .wdata  (psr_q),
        .rdata  (stack_rdata),
        .pop_ok (pop_ok),
        .full   (full),
        .empty  (empty),
        .err    (stack_err)
    );

    assign f_n      = psr_q[PSR_N];
    assign f_z      = psr_q[PSR_Z];
    assign f_c      = psr_q[PSR_C];
    assign f_v      = psr_q[PSR_V];
    assign flag_new = {n_in, z_in, c_in, v_in};

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = f_z;
            COND_NE: cond_true = ~f_z;
            COND_CS: cond_true = f_c;
            COND_CC: cond_true = ~f_c;
            COND_MI: cond_true = f_n;
            COND_PL: cond_true = ~f_n;
            COND_VS: cond_true = f_v;
            COND_VC: cond_true = ~f_v;
            COND_HI: cond_true = f_c & ~f_z;
            COND_LS: cond_true = ~f_c | f_z;
            COND_GE: cond_true = (f_n == f_v);
            COND_LT: cond_true = (f_n != f_v);
            COND_GT: cond_true = ~f_z & (f_n == f_v);
            COND_LE: cond_true = f_z | (f_n != f_v);
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
        endcase
    end

    // A successful pop restores the saved flags and discards any ALU write.
    always_comb begin
        psr_d = psr_q;
        if (pop_ok) begin
            psr_d = stack_rdata;
        end else if (flag_we) begin
            psr_d = (psr_q & ~flag_mask) | (flag_new & flag_mask);
        end
        taken_d       = cond_valid ? cond_true : taken_q;
        taken_valid_d = cond_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psr_q         <= '0;
            taken_q       <= 1'b0;
            taken_valid_q <= 1'b0;
        end else begin
            psr_q         <= psr_d;
            taken_q       <= taken_d;
            taken_valid_q <= taken_valid_d;
        end
    end

    assign psr         = psr_q;
    assign carry_out   = psr_q[PSR_C];
    assign taken       = taken_q;
    assign taken_valid = taken_valid_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb/tb_alu_flag_unit.sv - self-checking bench for alu_flag_unit
module tb_alu_flag_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, flag_we, c_in, v_in, n_in, z_in;
    logic [3:0] flag_mask, cond;
    logic       cond_valid, push, pop, err_clr;
    logic       taken, taken_valid, carry_out, full, empty, stack_err;
    logic [3:0] psr;

    int checks = 0;
    int errors = 0;

    // Reference state: flags as named bits, stack as a queue.
    bit       m_n, m_z, m_c, m_v;
    bit [3:0] m_stack[$];
    bit       m_err, m_taken, m_tv;

    alu_flag_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flag_we(flag_we),
        .c_in(c_in), .v_in(v_in), .n_in(n_in), .z_in(z_in),
        .flag_mask(flag_mask), .cond(cond), .cond_valid(cond_valid),
        .taken(taken), .taken_valid(taken_valid),
        .push(push), .pop(pop), .psr(psr), .carry_out(carry_out),
        .full(full), .empty(empty), .stack_err(stack_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    function automatic bit cond_holds(int code, bit n, bit z, bit c, bit v);
        bit ge;
        ge = (n == v);
        case (code)
            0: return z;
            1: return !z;
            2: return c;
            3: return !c;
            4: return n;
            5: return !n;
            6: return v;
            7: return !v;
            8: return c && !z;
            9: return !c || z;
            10: return ge;
            11: return !ge;
            12: return !z && ge;
            13: return z || !ge;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0; flag_we = 0; c_in = 0; v_in = 0; n_in = 0; z_in = 0;
        flag_mask = 4'h0; cond = 4'h0; cond_valid = 0; push = 0; pop = 0; err_clr = 0;
    endtask

    task automatic model_step();
        bit [3:0] old_psr;
        bit       new_err;
        if (reset) begin
            {m_n, m_z, m_c, m_v} = 4'b0;
            m_stack.delete();
            m_err = 0; m_taken = 0; m_tv = 0;
            return;
        end
        old_psr = {m_n, m_z, m_c, m_v};
        m_tv = cond_valid;
        if (cond_valid) m_taken = cond_holds(int'(cond), m_n, m_z, m_c, m_v);
        if (flag_we) begin
            if (flag_mask[3]) m_n = n_in;
            if (flag_mask[2]) m_z = z_in;
            if (flag_mask[1]) m_c = c_in;
            if (flag_mask[0]) m_v = v_in;
        end
        new_err = 0;
        if (push && !pop) begin
            if (m_stack.size() == DEPTH) new_err = 1;
            else m_stack.push_back(old_psr);
        end
        if (pop && !push) begin
            if (m_stack.size() == 0) new_err = 1;
            else {m_n, m_z, m_c, m_v} = m_stack.pop_back();
        end
        if (new_err) m_err = 1;
        else if (err_clr) m_err = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".psr"}, psr, {m_n, m_z, m_c, m_v});
        check({tag, ".carry"}, {3'b0, carry_out}, {3'b0, m_c});
        check({tag, ".taken"}, {3'b0, taken}, {3'b0, m_taken});
        check({tag, ".tvalid"}, {3'b0, taken_valid}, {3'b0, m_tv});
        check({tag, ".full"}, {3'b0, full}, {3'b0, (m_stack.size() == DEPTH)});
        check({tag, ".empty"}, {3'b0, empty}, {3'b0, (m_stack.size() == 0)});
        check({tag, ".err"}, {3'b0, stack_err}, {3'b0, m_err});
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        idle();
    endtask

    task automatic write_flags(input logic [3:0] nzcv, input logic [3:0] mask);
        flag_we = 1; {n_in, z_in, c_in, v_in} = nzcv; flag_mask = mask;
    endtask

    initial begin
        idle();
        reset = 1;
        tick("reset");
        check("reset_psr", psr, 4'b0000);
        check("reset_empty", {3'b0, empty}, 4'h1);

        // 5-5: C=1, Z=1
        write_flags(4'b0110, 4'hF);
        tick("alu55");
        check("alu55_psr", psr, 4'b0110);
        cond = 4'h0; cond_valid = 1;
        tick("eq");
        check("eq_taken", {3'b0, taken}, 4'h1);
        cond = 4'h8; cond_valid = 1;
        tick("hi");
        check("hi_taken", {3'b0, taken}, 4'h0);
        tick("hold");
        check("tv_drop", {3'b0, taken_valid}, 4'h0);

        // Same-cycle write and evaluate uses the old flags.
        write_flags(4'b0000, 4'hF);
        tick("clr");
        write_flags(4'b1001, 4'b1001); cond = 4'hA; cond_valid = 1;
        tick("ge_old");
        check("ge_old_taken", {3'b0, taken}, 4'h1);
        cond = 4'hB; cond_valid = 1;
        tick("lt");
        check("lt_taken", {3'b0, taken}, 4'h0);
        check("lt_psr", psr, 4'b1001);

        // Masked update of C only.
        write_flags(4'b0110, 4'hF);
        tick("set0110");
        write_flags(4'b0000, 4'b0010);
        tick("maskc");
        check("maskc_psr", psr, 4'b0100);
        check("maskc_carry", {3'b0, carry_out}, 4'h0);

        // Fill the stack; each push also writes a new value so entries differ.
        write_flags(4'h1, 4'hF);
        tick("seed");
        for (int i = 0; i < DEPTH; i++) begin
            push = 1; write_flags(4'(i + 2), 4'hF);
            tick("push");
        end
        check("fill_full", {3'b0, full}, 4'h1);
        push = 1;
        tick("push_over");
        check("push_over_err", {3'b0, stack_err}, 4'h1);
        err_clr = 1;
        tick("errclr");
        for (int i = 0; i < DEPTH; i++) begin
            pop = 1;
            tick("pop");
            check("pop_order", psr, 4'(DEPTH - i));
        end
        check("drain_empty", {3'b0, empty}, 4'h1);
        pop = 1;
        tick("pop_under");
        check("pop_under_psr", psr, 4'h1);

        // Simultaneous events.
        push = 1;
        tick("push1");
        push = 1; pop = 1;
        tick("pushpop");
        write_flags(4'hE, 4'hF); pop = 1;
        tick("pop_we");
        check("pop_we_psr", psr, 4'h1);
        pop = 1; err_clr = 1;
        tick("clr_vs_set");
        check("clr_vs_set_err", {3'b0, stack_err}, 4'h1);

        // Reset mid-sequence.
        push = 1; tick("p_a");
        push = 1; tick("p_b");
        reset = 1; cond_valid = 1; cond = 4'hE;
        tick("mid_reset");
        check("mid_reset_tv", {3'b0, taken_valid}, 4'h0);
        check("mid_reset_psr", psr, 4'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            flag_we    = $urandom_range(0, 1);
            {n_in, z_in, c_in, v_in} = 4'($urandom);
            flag_mask  = 4'($urandom);
            cond       = 4'($urandom);
            cond_valid = $urandom_range(0, 1);
            push       = ($urandom_range(0, 3) == 0);
            pop        = ($urandom_range(0, 3) == 0);
            err_clr    = ($urandom_range(0, 7) == 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Consumer end of the 8-bit ALU's status outputs (C, V, N, Z).
- Latches flags into a processor status register (PSR) under per-flag mask control.
- Evaluates 4-bit branch condition codes against the PSR with a registered result.
- Provides a small LIFO shadow stack so interrupt entry/exit can save and restore flags; also exports current carry for multi-precision add/subtract chains.

Parameters:
DEPTH, 4, number of PSR entries in the shadow stack (power of two, 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flag_we  input  1  write flags from ALU this cycle
c_in  input  1  ALU carry (1 = carry out / no borrow, since subtract is A + ~B + 1)
v_in  input  1  ALU signed overflow
n_in  input  1  ALU negative
z_in  input  1  ALU zero
flag_mask  input  4  per-flag update enable, order {N,Z,C,V}
cond  input  4  condition code to evaluate
cond_valid  input  1  evaluate cond this cycle
taken  output  1  registered condition result
taken_valid  output  1  registered strobe, high one cycle after cond_valid
push  input  1  save PSR to shadow stack
pop  input  1  restore PSR from shadow stack
psr  output  4  current flags {N,Z,C,V}
carry_out  output  1  psr C bit, for ADC/SBC carry-in
full  output  1  stack holds DEPTH entries
empty  output  1  stack holds zero entries
stack_err  output  1  sticky: push when full or pop when empty
err_clr  input  1  clears stack_err

Behaviour:
- Reset values, applied at the first rising edge with reset=1: psr=0000, taken=0, taken_valid=0, stack pointer=0, empty=1, full=0, stack_err=0. Stack contents are don't-care.
- Reset mid-operation overrides all inputs that cycle; any pending taken_valid is dropped.
- PSR update: on flag_we, each psr bit whose flag_mask bit is 1 takes the matching *_in value; masked bits hold.
- Condition evaluation is combinational on the registered psr (pre-update value). It is registered into taken, and taken_valid=cond_valid delayed one cycle. Latency is 1 cycle.
- If cond_valid and flag_we occur in the same cycle, the evaluation uses the old flags; there is no forwarding.
- taken holds its value when cond_valid=0.
- Condition encodings:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F NV: 0
- Push (push=1, pop=0, not full):
  - Writes the current registered psr at the stack pointer, then increments the pointer.
  - If flag_we occurs in the same cycle, the stack stores the old psr and the PSR takes the new value.
- Pop (pop=1, push=0, not empty):
  - Decrements the pointer and loads psr from the top entry.
  - Pop overrides a simultaneous flag_we; the ALU flags are discarded.
- push and pop in the same cycle: both are ignored, the pointer and psr are unchanged, and stack_err is not set. flag_we still applies.
- Push when full or pop when empty: the operation is ignored, the pointer is unchanged, and stack_err is set. psr still follows flag_we.
- stack_err stays set until err_clr or reset. If err_clr and a new error occur in the same cycle, the set wins.
- full = (pointer==DEPTH); empty = (pointer==0). Both are derived from the registered pointer. The pointer is $clog2(DEPTH)+1 bits wide and never wraps.
- carry_out = psr[1], direct from the register.

Decomposition:
- Shared package holds:
  - condition code constants (COND_EQ..COND_NV)
  - PSR bit indices (PSR_N=3, PSR_Z=2, PSR_C=1, PSR_V=0)
  - the 4-bit PSR type
- The ALU decoder and the branch unit reuse this package.
- One sub-module, flag_stack: a DEPTH x 4 LIFO with push/pop/full/empty/err. The condition evaluator stays inline.

Test Plan:
- Reset, then ALU 5-5 (c=1, v=0, n=0, z=1), flag_we, mask=1111 -> psr=0110. Then cond=0 (EQ) -> taken=1 next cycle, taken_valid pulse of one cycle; cond=8 (HI) -> taken=0.
- psr=0000; flag_we with n=1, v=1 and mask=1001; same cycle cond=A (GE) -> taken=1 (uses old flags). Next cycle cond=B (LT) -> taken=0 (N==V); psr=1001.
- Masked update: psr=0110; flag_we with all inputs 0 and mask=0010 -> psr=0100; carry_out=0.
- Stack with DEPTH=4: push 4 distinct psr values -> full=1; 5th push -> stack_err=1, pointer unchanged. Pop 4 -> psr restored in reverse order, empty=1; 5th pop -> psr unchanged.
- Simultaneous events:
  - push+pop -> pointer and psr unchanged.
  - pop+flag_we -> psr equals the popped value.
  - err_clr+new error in the same cycle -> stack_err stays 1.
- Reset asserted mid-sequence (2 entries pushed, cond_valid high) -> next cycle psr=0, empty=1, taken_valid=0, stack_err=0.
